// File: rtl/mpc_types.sv
// Shared types and widths for the memctl writeback receiver.
`default_nettype none

package mpc_types;
   localparam int MEMCTL_BEAT_W  = 128;
   localparam int MEMCTL_LINE_W  = 256;
   localparam int MEMCTL_NLINE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AW   = 2'd1,
      W0   = 2'd2,
      W1   = 2'd3
   } memctl_wb_state_e;

   typedef struct packed {
      logic [MEMCTL_NLINE_W-1:0] nline;
      logic [MEMCTL_LINE_W-1:0]  data;
   } wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/memctl_wb_queue.sv
// In-order writeback queue: line storage, write/issue/retire pointers and id lookup.
`default_nettype none

module memctl_wb_queue
   import mpc_types::*;
#(
   parameter int NlineWidth = 16,
   parameter int Depth      = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [NlineWidth-1:0]    push_nline_i,
   input  logic [MEMCTL_LINE_W-1:0] push_data_i,
   input  logic                     issue_done_i,
   input  logic                     retire_i,
   input  logic [NlineWidth-1:0]    chk_nline_i,
   input  logic                     chk_incoming_i,
   output logic                     full_o,
   output logic                     issuable_o,
   output logic                     issuable_next_o,
   output logic                     outstanding_o,
   output logic [NlineWidth-1:0]    iss_nline_o,
   output logic [MEMCTL_LINE_W-1:0] iss_data_o,
   output logic [NlineWidth-1:0]    ret_nline_o,
   output logic                     chk_hit_o
);
   localparam int PW = $clog2(Depth);

   logic [PW:0]               wr_ptr_q, iss_ptr_q, ret_ptr_q;
   logic [PW:0]               occ_w;
   logic [PW-1:0]             off_w;
   logic                      hit_w;
   logic [NlineWidth-1:0]     nline_q [Depth];
   logic [MEMCTL_LINE_W-1:0]  data_q  [Depth];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         iss_ptr_q <= '0;
         ret_ptr_q <= '0;
      end else begin
         if (push_i)       wr_ptr_q  <= wr_ptr_q + 1'b1;
         if (issue_done_i) iss_ptr_q <= iss_ptr_q + 1'b1;
         if (retire_i)     ret_ptr_q <= ret_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         nline_q[wr_ptr_q[PW-1:0]] <= push_nline_i;
         data_q[wr_ptr_q[PW-1:0]]  <= push_data_i;
      end
   end

   assign occ_w           = wr_ptr_q - ret_ptr_q;
   assign full_o          = (occ_w == (PW+1)'(Depth));
   assign issuable_o      = (iss_ptr_q != wr_ptr_q);
   assign issuable_next_o = ((iss_ptr_q + 1'b1) != wr_ptr_q);
   assign outstanding_o   = (iss_ptr_q != ret_ptr_q);
   assign iss_nline_o     = nline_q[iss_ptr_q[PW-1:0]];
   assign iss_data_o      = data_q[iss_ptr_q[PW-1:0]];
   assign ret_nline_o     = nline_q[ret_ptr_q[PW-1:0]];

   // A slot is live when its distance from ret_ptr is below the occupancy.
   always_comb begin
      hit_w = 1'b0;
      off_w = '0;
      for (int i = 0; i < Depth; i++) begin
         off_w = PW'(i) - ret_ptr_q[PW-1:0];
         if (({1'b0, off_w} < occ_w) && (nline_q[i] == chk_nline_i)) hit_w = 1'b1;
      end
   end

   assign chk_hit_o = hit_w | chk_incoming_i;
endmodule

`default_nettype wire

// File: rtl/memctl_wb_rx.sv
// Memctl writeback receiver: queues dirty lines and drains them as AW + two W beats.
// Optional MEMCTL_WB_RX_PERF_EN adds saturating perf_lines / perf_stall counters.
`default_nettype none

module memctl_wb_rx
   import mpc_types::*;
#(
   parameter int NlineWidth     = 16,
   parameter int Depth          = 4,
   parameter int AddrWidth      = 32,
   parameter int LineOffsetBits = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     memctl_wvalid,
   output logic                     memctl_wready,
   input  logic [NlineWidth-1:0]    memctl_wid,
   input  logic [MEMCTL_LINE_W-1:0] memctl_wdata,
   output logic                     mem_awvalid,
   input  logic                     mem_awready,
   output logic [AddrWidth-1:0]     mem_awaddr,
   output logic                     mem_wvalid,
   input  logic                     mem_wready,
   output logic [MEMCTL_BEAT_W-1:0] mem_wdata,
   output logic                     mem_wlast,
   input  logic                     mem_bvalid,
   input  logic [1:0]               mem_bresp,
   input  logic [NlineWidth-1:0]    chk_nline,
   output logic                     chk_hit,
   output logic                     err,
   output logic [NlineWidth-1:0]    err_nline
`ifdef MEMCTL_WB_RX_PERF_EN
   ,
   output logic [31:0]              perf_lines,
   output logic [31:0]              perf_stall
`endif
);
   memctl_wb_state_e          state_q, state_d;
   logic                      err_q, err_d;
   logic [NlineWidth-1:0]     err_nline_q, err_nline_d;
   logic                      push_w, issue_done_w, retire_w, chk_incoming_w;
   logic                      full_w, issuable_w, issuable_next_w, outstanding_w;
   logic [NlineWidth-1:0]     iss_nline_w, ret_nline_w;
   logic [MEMCTL_LINE_W-1:0]  iss_data_w;
   logic                      unused_w;

   assign unused_w       = mem_bresp[0];
   assign memctl_wready  = !full_w;
   assign push_w         = memctl_wvalid && memctl_wready;
   assign chk_incoming_w = push_w && (memctl_wid == chk_nline);
   assign retire_w       = mem_bvalid && outstanding_w;

   memctl_wb_queue #(
      .NlineWidth (NlineWidth),
      .Depth      (Depth)
   ) u_queue (
      .clk             (clk),
      .rst_n           (rst_n),
      .push_i          (push_w),
      .push_nline_i    (memctl_wid),
      .push_data_i     (memctl_wdata),
      .issue_done_i    (issue_done_w),
      .retire_i        (retire_w),
      .chk_nline_i     (chk_nline),
      .chk_incoming_i  (chk_incoming_w),
      .full_o          (full_w),
      .issuable_o      (issuable_w),
      .issuable_next_o (issuable_next_w),
      .outstanding_o   (outstanding_w),
      .iss_nline_o     (iss_nline_w),
      .iss_data_o      (iss_data_w),
      .ret_nline_o     (ret_nline_w),
      .chk_hit_o       (chk_hit)
   );

   always_comb begin
      state_d      = state_q;
      issue_done_w = 1'b0;
      case (state_q)
         IDLE: if (issuable_w) state_d = AW;
         AW:   if (mem_awready) state_d = W0;
         W0:   if (mem_wready) state_d = W1;
         W1: begin
            if (mem_wready) begin
               issue_done_w = 1'b1;
               state_d      = issuable_next_w ? AW : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs depend only on registered state and storage, never on a ready.
   assign mem_awvalid = (state_q == AW);
   assign mem_awaddr  = AddrWidth'(iss_nline_w) << LineOffsetBits;
   assign mem_wvalid  = (state_q == W0) || (state_q == W1);
   assign mem_wlast   = (state_q == W1);
   assign mem_wdata   = (state_q == W1) ? iss_data_w[MEMCTL_LINE_W-1:MEMCTL_BEAT_W]
                                        : iss_data_w[MEMCTL_BEAT_W-1:0];

   always_comb begin
      err_d       = err_q;
      err_nline_d = err_nline_q;
      if (mem_bvalid) begin
         if (!outstanding_w) begin
            err_d = 1'b1;
         end else if (mem_bresp[1] && !err_q) begin
            err_d       = 1'b1;
            err_nline_d = ret_nline_w;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         err_q       <= 1'b0;
         err_nline_q <= '0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         err_nline_q <= err_nline_d;
      end
   end

   assign err       = err_q;
   assign err_nline = err_nline_q;

`ifdef MEMCTL_WB_RX_PERF_EN
   logic [31:0] perf_lines_q, perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_lines_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (retire_w && (perf_lines_q != '1)) perf_lines_q <= perf_lines_q + 1'b1;
         if (memctl_wvalid && !memctl_wready && (perf_stall_q != '1))
            perf_stall_q <= perf_stall_q + 1'b1;
      end
   end

   assign perf_lines = perf_lines_q;
   assign perf_stall = perf_stall_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_memctl_wb_rx.sv
// Randomized scoreboard bench for memctl_wb_rx against a queue-level reference model.
`default_nettype none

module tb_memctl_wb_rx;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         memctl_wvalid, memctl_wready;
   logic [15:0]  memctl_wid;
   logic [255:0] memctl_wdata;
   logic         mem_awvalid, mem_awready;
   logic [31:0]  mem_awaddr;
   logic         mem_wvalid, mem_wready;
   logic [127:0] mem_wdata;
   logic         mem_wlast;
   logic         mem_bvalid;
   logic [1:0]   mem_bresp;
   logic [15:0]  chk_nline;
   logic         chk_hit, err;
   logic [15:0]  err_nline;
`ifdef MEMCTL_WB_RX_PERF_EN
   logic [31:0]  perf_lines, perf_stall;
`endif

   always #5 clk = ~clk;

   memctl_wb_rx #(
      .NlineWidth(16), .Depth(DEPTH), .AddrWidth(32), .LineOffsetBits(5)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .memctl_wvalid(memctl_wvalid), .memctl_wready(memctl_wready),
      .memctl_wid(memctl_wid), .memctl_wdata(memctl_wdata),
      .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_wlast(mem_wlast), .mem_bvalid(mem_bvalid), .mem_bresp(mem_bresp),
      .chk_nline(chk_nline), .chk_hit(chk_hit), .err(err), .err_nline(err_nline)
`ifdef MEMCTL_WB_RX_PERF_EN
      , .perf_lines(perf_lines), .perf_stall(perf_stall)
`endif
   );

   // Reference model: lines accepted but not yet retired, in arrival order.
   logic [15:0]  pend_q[$];
   logic [31:0]  exp_aw_q[$];
   logic [128:0] exp_w_q[$];
   int           inflight_m;
   bit           err_m;
   logic [15:0]  errn_m;
   int           n_cmp = 0;
   int           n_bad = 0;

   int           p_aw = 100, p_w = 100, p_b = 100, p_err = 0;
   bit           b_en = 1'b1;
   bit           spurious_req = 1'b0;
   logic [1:0]   bresp_plan[$];
   logic [15:0]  pool[6] = '{16'h0033, 16'h0012, 16'h0101, 16'h7FFF, 16'hFFFF, 16'h0000};

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor / scoreboard: samples just before each rising edge.
   initial begin : monitor
      bit           hold_w, hold_aw, exp_rdy, hit;
      logic [128:0] held_w, got_w, ew;
      logic [31:0]  held_aw, ea;
      logic [15:0]  rid;
      hold_w = 0; hold_aw = 0; held_w = '0; held_aw = '0;
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            hold_w = 0; hold_aw = 0;
            continue;
         end
         check("err", err, err_m);
         check("err_nline", err_nline, errn_m);
         exp_rdy = (pend_q.size() < DEPTH);
         check("memctl_wready", memctl_wready, exp_rdy);
         hit = 0;
         foreach (pend_q[i]) if (pend_q[i] == chk_nline) hit = 1;
         if (memctl_wvalid && exp_rdy && memctl_wid == chk_nline) hit = 1;
         check("chk_hit", chk_hit, hit);

         got_w = {mem_wlast, mem_wdata};
         if (hold_w) begin
            check("w_hold_valid", mem_wvalid, 1'b1);
            check("w_hold_payload", got_w, held_w);
         end
         if (hold_aw) begin
            check("aw_hold_valid", mem_awvalid, 1'b1);
            check("aw_hold_addr", mem_awaddr, held_aw);
         end
         hold_w  = mem_wvalid && !mem_wready;   held_w  = got_w;
         hold_aw = mem_awvalid && !mem_awready; held_aw = mem_awaddr;

         if (mem_bvalid) begin
            if (inflight_m > 0) begin
               rid = pend_q.pop_front();
               inflight_m--;
               if (mem_bresp[1] && !err_m) begin err_m = 1; errn_m = rid; end
            end else begin
               err_m = 1;
            end
         end
         if (mem_awvalid && mem_awready) begin
            if (exp_aw_q.size() == 0) fail_now("unexpected_aw");
            else begin ea = exp_aw_q.pop_front(); check("awaddr", mem_awaddr, ea); end
         end
         if (mem_wvalid && mem_wready) begin
            if (exp_w_q.size() == 0) fail_now("unexpected_w_beat");
            else begin
               ew = exp_w_q.pop_front();
               check("w_beat", got_w, ew);
               if (ew[128]) inflight_m++;
            end
         end
         if (memctl_wvalid && exp_rdy) begin
            pend_q.push_back(memctl_wid);
            exp_aw_q.push_back(32'(memctl_wid) * 32);
            exp_w_q.push_back({1'b0, memctl_wdata[127:0]});
            exp_w_q.push_back({1'b1, memctl_wdata[255:128]});
         end
      end
   end

   // Downstream responder and lookup stimulus.
   initial begin : downstream
      mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = 0; chk_nline = 0;
      forever begin
         @(negedge clk);
         mem_awready = ($urandom_range(99) < p_aw);
         mem_wready  = ($urandom_range(99) < p_w);
         mem_bvalid  = 0;
         mem_bresp   = 2'b00;
         if (spurious_req) begin
            mem_bvalid   = 1;
            spurious_req = 0;
         end else if (b_en && inflight_m > 0 && $urandom_range(99) < p_b) begin
            mem_bvalid = 1;
            if (bresp_plan.size() > 0) mem_bresp = bresp_plan.pop_front();
            else if ($urandom_range(99) < p_err) mem_bresp = 2'b10;
            else mem_bresp = {1'b0, 1'($urandom_range(1))};
         end
         chk_nline = pool[$urandom_range(5)];
      end
   end

   function automatic logic [255:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push_line(input logic [15:0] id, input logic [255:0] d);
      memctl_wid = id; memctl_wdata = d; memctl_wvalid = 1;
      for (int k = 0; k < 300; k++) begin
         #3;
         if (memctl_wready) begin
            @(negedge clk);
            memctl_wvalid = 0;
            return;
         end
         @(negedge clk);
      end
      memctl_wvalid = 0;
      fail_now("push_timeout");
   endtask

   task automatic wait_empty(input int max_cycles);
      for (int k = 0; k < max_cycles; k++) begin
         if (pend_q.size() == 0) return;
         @(negedge clk);
      end
      fail_now("drain_timeout");
   endtask

   task automatic wait_inflight(input int n, input int max_cycles);
      for (int k = 0; k < max_cycles; k++) begin
         if (inflight_m >= n) return;
         @(negedge clk);
      end
      fail_now("inflight_timeout");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      pend_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); bresp_plan.delete();
      inflight_m = 0; err_m = 0; errn_m = '0;
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      rst_n = 0; memctl_wvalid = 0; memctl_wid = 0; memctl_wdata = '0;
      inflight_m = 0; err_m = 0; errn_m = '0;
      repeat (3) @(negedge clk);
      #3;
      check("rst_wready", memctl_wready, 1'b1);
      check("rst_awvalid", mem_awvalid, 1'b0);
      check("rst_wvalid", mem_wvalid, 1'b0);
      check("rst_wlast", mem_wlast, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_err_nline", err_nline, 16'h0);
      @(negedge clk);
      rst_n = 1;

      // Single line, everything ready.
      push_line(16'h0012, rand_line());
      wait_empty(50);
      check("single_aw_drained", exp_aw_q.size(), 0);
      check("single_w_drained", exp_w_q.size(), 0);

      // Fill the queue with the address channel blocked.
      p_aw = 0; b_en = 0;
      @(negedge clk);
      push_line(16'h0033, rand_line());
      push_line(16'h0100, rand_line());
      push_line(16'h0101, rand_line());
      push_line(16'h0033, rand_line());
      memctl_wid = 16'h0444; memctl_wdata = rand_line(); memctl_wvalid = 1;
      for (int k = 0; k < 4; k++) begin
         #3;
         check("full_stall", memctl_wready, 1'b0);
         @(negedge clk);
      end
      p_aw = 100; b_en = 1;
      push_line(16'h0444, memctl_wdata);
      wait_empty(100);

      // Error on the middle of three lines; later error leaves the id alone.
      b_en = 0;
      push_line(16'h0101, rand_line());
      push_line(16'h0202, rand_line());
      push_line(16'h0303, rand_line());
      wait_inflight(3, 100);
      bresp_plan.push_back(2'b00);
      bresp_plan.push_back(2'b10);
      bresp_plan.push_back(2'b00);
      b_en = 1;
      wait_empty(100);
      @(negedge clk); #3;
      check("err_set", err, 1'b1);
      check("err_first_id", err_nline, 16'h0202);
      @(negedge clk);
      bresp_plan.push_back(2'b10);
      push_line(16'h0404, rand_line());
      wait_empty(100);
      @(negedge clk); #3;
      check("err_id_sticky", err_nline, 16'h0202);

      // Spurious response with nothing outstanding.
      do_reset();
      #3;
      check("err_after_reset", err, 1'b0);
      @(negedge clk);
      spurious_req = 1;
      repeat (3) @(negedge clk);
      #3;
      check("spurious_err", err, 1'b1);
      check("spurious_err_nline", err_nline, 16'h0000);

      // Random traffic with backpressure on every channel.
      do_reset();
      p_aw = 70; p_w = 60; p_b = 50; p_err = 8; b_en = 1;
      for (int c = 0; c < 1500; c++) begin
         memctl_wvalid = ($urandom_range(99) < 50);
         memctl_wid    = pool[$urandom_range(5)];
         memctl_wdata  = rand_line();
         @(negedge clk);
      end
      memctl_wvalid = 0;
      p_aw = 100; p_w = 100; p_b = 100;
      wait_empty(500);
      repeat (3) @(negedge clk);
      check("final_aw_drained", exp_aw_q.size(), 0);
      check("final_w_drained", exp_w_q.size(), 0);
      check("final_inflight", inflight_m, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
